// File: rtl/srl_pipe_ctrl_if.sv
// Handshake and control bundle between a stream producer/consumer
// and the SRL flow controller.
interface srl_pipe_ctrl_if #(
    parameter int C_CNT_WIDTH = 3
);
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_last;
    logic                   out_ready;
    logic                   flush;
    logic                   srl_ce;
    logic                   srl_rst;
    logic [C_CNT_WIDTH-1:0] occupancy;
    logic                   busy;
    logic                   drain_done;

    modport master (
        output in_valid,
        output in_last,
        output out_ready,
        output flush,
        input  in_ready,
        input  out_valid,
        input  out_last,
        input  srl_ce,
        input  srl_rst,
        input  occupancy,
        input  busy,
        input  drain_done
    );

    modport slave (
        input  in_valid,
        input  in_last,
        input  out_ready,
        input  flush,
        output in_ready,
        output out_valid,
        output out_last,
        output srl_ce,
        output srl_rst,
        output occupancy,
        output busy,
        output drain_done
    );
endinterface

// File: rtl/srl_pipe_ctrl.sv
// Flow controller for a bank of equal-depth SRL delay lines sharing
// one clock enable; turns valid/ready handshakes into srl_ce stalls.
module srl_pipe_ctrl #(
    parameter int C_DEPTH     = 4,
    parameter int C_CNT_WIDTH = 3
) (
    input  logic          clk,
    input  logic          rst,
    srl_pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [C_DEPTH-1:0]     valid_sr;
    logic [C_DEPTH-1:0]     last_sr;
    logic [C_DEPTH-1:0]     valid_nx;
    logic [C_DEPTH-1:0]     last_nx;
    logic [C_CNT_WIDTH-1:0] occ_q;
    logic [C_CNT_WIDTH-1:0] occ_d;
    logic                   drain_done_q;
    logic                   drain_done_d;
    logic                   srl_ce;
    logic                   in_ready;
    logic                   in_fire;
    logic                   out_fire;
    logic                   out_valid;
    logic                   out_last;

    assign out_valid = valid_sr[C_DEPTH-1];
    assign out_last  = last_sr[C_DEPTH-1];

    // flush forces the shift so the SRLs see their clear enabled
    assign srl_ce   = bus.flush | ~out_valid | bus.out_ready;
    assign in_ready = srl_ce & (state_q != DRAIN) & ~bus.flush;
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = out_valid & bus.out_ready;

    generate
        if (C_DEPTH == 1) begin : g_d1
            assign valid_nx = in_fire;
            assign last_nx  = in_fire & bus.in_last;
        end else begin : g_dn
            assign valid_nx = {valid_sr[C_DEPTH-2:0], in_fire};
            assign last_nx  = {last_sr[C_DEPTH-2:0],
                               in_fire & bus.in_last};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_sr <= '0;
            last_sr  <= '0;
        end else if (bus.flush) begin
            valid_sr <= '0;
            last_sr  <= '0;
        end else if (srl_ce) begin
            valid_sr <= valid_nx;
            last_sr  <= last_nx;
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (bus.flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q
                  + C_CNT_WIDTH'(in_fire)
                  - C_CNT_WIDTH'(out_fire);
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_done_d = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        state_d = bus.in_last ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (in_fire && bus.in_last) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire && out_last) begin
                        state_d      = IDLE;
                        drain_done_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // drain_done is a flop: it is high the cycle the FSM is back in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            occ_q        <= '0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_last   = out_last;
    assign bus.srl_ce     = srl_ce;
    assign bus.srl_rst    = bus.flush;
    assign bus.occupancy  = occ_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.drain_done = drain_done_q;

endmodule
